// File: rtl/button_event_arbiter.sv
// Classifies per-button press/release pulses into SHORT/LONG/DOUBLE gestures and
// arbitrates them round-robin onto a single valid/ready event port.
//
// state     | meaning
// IDLE      | released, no gesture in progress
// PRESSED   | first press held, counting ticks toward LONG
// LONG_HELD | LONG already reported, waiting for release
// WAIT_2ND  | released after a short press, waiting for a second press
// PRESSED2  | second press held, DOUBLE reported on release
module button_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int CLK_PER_MS = 100000,
  parameter int LONG_MS    = 1000,
  parameter int DBL_MS     = 300,
  parameter int ID_W       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_pe,
  input  logic [N_BTN-1:0] btn_ne,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  output logic [N_BTN-1:0] hold_active,
  output logic [N_BTN-1:0] ovf
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [15:0] LONG_CNT = 16'(LONG_MS);
  localparam logic [15:0] DBL_CNT  = 16'(DBL_MS);
  localparam logic [1:0] T_SHORT  = 2'b01;
  localparam logic [1:0] T_LONG   = 2'b10;
  localparam logic [1:0] T_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_2ND  = 3'd3,
    PRESSED2  = 3'd4
  } state_t;

  logic [PW-1:0]    presc_q;
  logic             tick;
  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [15:0]      cnt_q [N_BTN];
  logic [15:0]      cnt_d [N_BTN];
  logic [N_BTN-1:0] pe_ok, ne_ok;
  logic [N_BTN-1:0] emit;
  logic [1:0]       emit_type [N_BTN];
  logic [N_BTN-1:0] pend_v_q;
  logic [1:0]       pend_type_q [N_BTN];
  logic [ID_W-1:0]  rr_q, grant_idx;
  logic             grant_any, load;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign tick = (presc_q == PW'(CLK_PER_MS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end

  // A simultaneous press and release on one button is treated as noise.
  assign pe_ok = btn_pe & ~btn_ne;
  assign ne_ok = btn_ne & ~btn_pe;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      emit[i]        = 1'b0;
      emit_type[i]   = T_SHORT;
      hold_active[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (pe_ok[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end
        end
        PRESSED: begin
          hold_active[i] = 1'b1;
          if (ne_ok[i]) begin
            state_d[i] = WAIT_2ND;
            cnt_d[i]   = '0;
          end else if (tick) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            if (sat_inc(cnt_q[i]) == LONG_CNT) begin
              emit[i]      = 1'b1;
              emit_type[i] = T_LONG;
              state_d[i]   = LONG_HELD;
            end
          end
        end
        LONG_HELD: begin
          hold_active[i] = 1'b1;
          if (ne_ok[i]) state_d[i] = IDLE;
        end
        WAIT_2ND: begin
          if (pe_ok[i]) begin
            state_d[i] = PRESSED2;
          end else if (tick) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            if (sat_inc(cnt_q[i]) == DBL_CNT) begin
              emit[i]      = 1'b1;
              emit_type[i] = T_SHORT;
              state_d[i]   = IDLE;
            end
          end
        end
        PRESSED2: begin
          hold_active[i] = 1'b1;
          if (ne_ok[i]) begin
            emit[i]      = 1'b1;
            emit_type[i] = T_DOUBLE;
            state_d[i]   = IDLE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Round-robin search starts one past the last granted button.
  always_comb begin : rr_pick
    logic [ID_W-1:0] cand;
    cand      = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = ID_W'((int'(rr_q) + k) % N_BTN);
      if (!grant_any && pend_v_q[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign load = (!evt_valid || evt_ready) && grant_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v_q <= '0;
      ovf      <= '0;
      for (int i = 0; i < N_BTN; i++) pend_type_q[i] <= 2'b00;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (emit[i]) begin
          pend_v_q[i]    <= 1'b1;
          pend_type_q[i] <= emit_type[i];
          if (pend_v_q[i] && !(load && grant_idx == ID_W'(i))) ovf[i] <= 1'b1;
        end else if (load && grant_idx == ID_W'(i)) begin
          pend_v_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= 2'b00;
      rr_q      <= '0;
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_id    <= grant_idx;
      evt_type  <= pend_type_q[grant_idx];
      rr_q      <= grant_idx;
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Random press/release traffic against a tick-timestamp gesture model with a
// per-button pending slot and round-robin output stage; compared every cycle.
module tb_button_event_arbiter;

  localparam int N_BTN      = 4;
  localparam int CLK_PER_MS = 10;
  localparam int LONG_MS    = 5;
  localparam int DBL_MS     = 3;
  localparam int ID_W       = 2;
  localparam int N_CYC      = 12000;

  localparam int P_UP = 0, P_DOWN = 1, P_LONG = 2, P_GAP = 3, P_DOWN2 = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N_BTN-1:0] btn_pe = '0;
  logic [N_BTN-1:0] btn_ne = '0;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic [ID_W-1:0]  evt_id;
  logic [1:0]       evt_type;
  logic [N_BTN-1:0] hold_active;
  logic [N_BTN-1:0] ovf;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN(N_BTN), .CLK_PER_MS(CLK_PER_MS), .LONG_MS(LONG_MS),
    .DBL_MS(DBL_MS), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_pe(btn_pe), .btn_ne(btn_ne),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .hold_active(hold_active), .ovf(ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // model: gestures timed by global tick count stamped at each press/release
  int m_edges, m_ticks;
  int ph [N_BTN];
  int mark [N_BTN];
  bit pv [N_BTN];
  int pt [N_BTN];
  bit m_ovf [N_BTN];
  bit m_valid;
  int m_id, m_type, m_rr;

  task automatic model_reset();
    m_edges = 0; m_ticks = 0;
    m_valid = 0; m_id = 0; m_type = 0; m_rr = 0;
    for (int i = 0; i < N_BTN; i++) begin
      ph[i] = P_UP; mark[i] = 0; pv[i] = 0; pt[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step();
    bit tick, load, pe_ok, ne_ok;
    int g, j;
    int emit_t [N_BTN];
    tick = (m_edges % CLK_PER_MS) == CLK_PER_MS - 1;
    m_edges++;
    if (tick) m_ticks++;
    load = 0; g = 0;
    if (!m_valid || evt_ready) begin
      for (int k = 1; k <= N_BTN; k++) begin
        j = (m_rr + k) % N_BTN;
        if (!load && pv[j]) begin load = 1; g = j; end
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      emit_t[i] = 0;
      pe_ok = btn_pe[i] && !btn_ne[i];
      ne_ok = btn_ne[i] && !btn_pe[i];
      case (ph[i])
        P_UP:    if (pe_ok) begin ph[i] = P_DOWN; mark[i] = m_ticks; end
        P_DOWN:  if (ne_ok) begin ph[i] = P_GAP; mark[i] = m_ticks; end
                 else if (m_ticks - mark[i] == LONG_MS) begin emit_t[i] = 2; ph[i] = P_LONG; end
        P_LONG:  if (ne_ok) ph[i] = P_UP;
        P_GAP:   if (pe_ok) ph[i] = P_DOWN2;
                 else if (m_ticks - mark[i] == DBL_MS) begin emit_t[i] = 1; ph[i] = P_UP; end
        default: if (ne_ok) begin emit_t[i] = 3; ph[i] = P_UP; end
      endcase
    end
    if (load) begin
      m_valid = 1; m_id = g; m_type = pt[g]; m_rr = g;
    end else if (evt_ready) begin
      m_valid = 0;
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (emit_t[i] != 0) begin
        if (pv[i] && !(load && g == i)) m_ovf[i] = 1;
        pv[i] = 1; pt[i] = emit_t[i];
      end else if (load && g == i) begin
        pv[i] = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    int exp_hold, exp_ovf;
    exp_hold = 0; exp_ovf = 0;
    for (int i = 0; i < N_BTN; i++) begin
      if (ph[i] == P_DOWN || ph[i] == P_LONG || ph[i] == P_DOWN2) exp_hold |= (1 << i);
      if (m_ovf[i]) exp_ovf |= (1 << i);
    end
    check_val("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      check_val("evt_id", 32'(evt_id), 32'(m_id));
      check_val("evt_type", 32'(evt_type), 32'(m_type));
    end
    check_val("hold_active", 32'(hold_active), 32'(exp_hold));
    check_val("ovf", 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_valid"}, 32'(evt_valid), 0);
    check_val({tag, "_id"}, 32'(evt_id), 0);
    check_val({tag, "_type"}, 32'(evt_type), 0);
    check_val({tag, "_hold"}, 32'(hold_active), 0);
    check_val({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  // Reset lands between clock edges so only the asynchronous path can clear outputs.
  task automatic do_reset();
    btn_pe = '0; btn_ne = '0;
    #2 reset_n = 1'b0;
    #1 check_reset_state("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  bit down [N_BTN];
  int rem [N_BTN];
  int ready_mode;

  task automatic drive_inputs();
    int r;
    btn_pe = '0; btn_ne = '0;
    for (int i = 0; i < N_BTN; i++) begin
      r = $urandom_range(0, 999);
      if (r < 4) begin
        btn_pe[i] = 1'b1; btn_ne[i] = 1'b1;
      end else if (r < 7) begin
        if (down[i]) btn_pe[i] = 1'b1; else btn_ne[i] = 1'b1;
      end else if (!down[i]) begin
        if (r < 70) begin
          btn_pe[i] = 1'b1; down[i] = 1;
          rem[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(40, 90) : $urandom_range(3, 35);
        end
      end else if (rem[i] == 0) begin
        btn_ne[i] = 1'b1; down[i] = 0;
      end else begin
        rem[i]--;
      end
    end
    case (ready_mode)
      0:       evt_ready = 1'b1;
      1:       evt_ready = 1'($urandom_range(0, 1));
      default: evt_ready = 1'b0;
    endcase
  endtask

  initial begin
    for (int i = 0; i < N_BTN; i++) begin down[i] = 0; rem[i] = 0; end
    ready_mode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("init_rst");
    reset_n = 1'b1;
    for (int c = 0; c < N_CYC; c++) begin
      if (c == 4000 || c == 8000) do_reset();
      if (c % 200 == 0) ready_mode = $urandom_range(0, 2);
      compare_outputs();
      drive_inputs();
      model_step();
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
